// File: rtl/floor_request_tracker.sv
// ---------------------------------------------------------------------------
// floor_request_tracker
//
// Receiving end of the per-floor call-button pulse path. It latches one-cycle
// call pulses into per-floor pending bits, which also drive the call lamps.
// It runs a collective (SCAN) direction scheduler and the door-hold timer.
// A floor's request is cleared when the car services it.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous reset, active LOW
//   req        one-cycle call pulses, bit i = floor i
//   cur_floor  current car floor index, meaningful when at_floor=1
//   at_floor   car is stopped and aligned at cur_floor
//   pending    latched outstanding requests (lamp drive)
//   move_up    motor up command
//   move_down  motor down command
//   door_open  door open command
//   serviced   one-hot, one-cycle pulse marking the floor just cleared
// ---------------------------------------------------------------------------
module floor_request_tracker #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  at_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] serviced
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DOOR = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  state_t                  state_q, state_d;
  dir_t                    last_dir_q, last_dir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [NUM_FLOORS-1:0]   serviced_q, serviced_d;

  logic                    above;
  logic                    below;
  logic                    here;
  logic                    req_here;
  logic                    floor_valid;
  logic                    enter_door;
  logic [NUM_FLOORS-1:0]   cur_onehot;
  int                      cur_idx;

  // Where the outstanding calls lie relative to the car. An out-of-range
  // floor index treats every pending call as below, so the car heads down.
  always_comb begin
    above       = 1'b0;
    below       = 1'b0;
    here        = 1'b0;
    req_here    = 1'b0;
    cur_onehot  = '0;
    cur_idx     = int'(cur_floor);
    floor_valid = (cur_idx < NUM_FLOORS);
    for (int j = 0; j < NUM_FLOORS; j++) begin
      if (!floor_valid) begin
        below = below | pending_q[j];
      end else if (j > cur_idx) begin
        above = above | pending_q[j];
      end else if (j < cur_idx) begin
        below = below | pending_q[j];
      end else begin
        here          = pending_q[j] & at_floor;
        req_here      = req[j];
        cur_onehot[j] = 1'b1;
      end
    end
  end

  // Scheduler next state. The door counter reloads on every DOOR entry and
  // whenever the current floor's button is pressed while the door is open.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d = S_DOOR;
        end else if (above) begin
          state_d    = S_UP;
          last_dir_d = DIR_UP;
        end else if (below) begin
          state_d    = S_DOWN;
          last_dir_d = DIR_DOWN;
        end
      end
      S_UP: begin
        if (at_floor) begin
          if (here) begin
            state_d = S_DOOR;
          end else if (!above && below) begin
            state_d    = S_DOWN;
            last_dir_d = DIR_DOWN;
          end else if (!above) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOWN: begin
        if (at_floor) begin
          if (here) begin
            state_d = S_DOOR;
          end else if (!below && above) begin
            state_d    = S_UP;
            last_dir_d = DIR_UP;
          end else if (!below) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (req_here) begin
          cnt_d = HOLD_RELOAD;
        end else if (cnt_q == '0) begin
          // Keep sweeping the way we were going if there is work that way.
          if (last_dir_q == DIR_UP && above) begin
            state_d = S_UP;
          end else if (below) begin
            state_d    = S_DOWN;
            last_dir_d = DIR_DOWN;
          end else if (above) begin
            state_d    = S_UP;
            last_dir_d = DIR_UP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    enter_door = (state_d == S_DOOR) && (state_q != S_DOOR);
    if (enter_door) begin
      cnt_d = HOLD_RELOAD;
    end
  end

  // Request latching. While the door is open the current floor's button is
  // absorbed; on DOOR entry the clear beats a simultaneous press.
  always_comb begin
    serviced_d = '0;
    if (state_q == S_DOOR) begin
      pending_d = pending_q | (req & ~cur_onehot);
    end else begin
      pending_d = pending_q | req;
    end
    if (enter_door) begin
      pending_d  = pending_d & ~cur_onehot;
      serviced_d = cur_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_dir_q <= DIR_UP;
      cnt_q      <= '0;
      pending_q  <= '0;
      serviced_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      serviced_q <= serviced_d;
    end
  end

  // Moore outputs decoded straight from the state register, so at most one
  // of them can ever be high.
  assign move_up   = (state_q == S_UP);
  assign move_down = (state_q == S_DOWN);
  assign door_open = (state_q == S_DOOR);
  assign pending   = pending_q;
  assign serviced  = serviced_q;

endmodule

// File: tb/tb_floor_request_tracker.sv
// ---------------------------------------------------------------------------
// tb_floor_request_tracker
//
// Directed bench for floor_request_tracker with NUM_FLOORS=4, HOLD_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_floor_request_tracker;

  localparam int NUM_FLOORS  = 4;
  localparam int FLOOR_W     = 2;
  localparam int HOLD_CYCLES = 4;

  logic                  clk;
  logic                  reset;
  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  at_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  move_up;
  logic                  move_down;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] serviced;
  logic [2:0]            outs;

  int checks = 0;
  int errors = 0;
  int doorCycles;
  int svcPulses;

  floor_request_tracker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cur_floor(cur_floor),
    .at_floor (at_floor),
    .pending  (pending),
    .move_up  (move_up),
    .move_down(move_down),
    .door_open(door_open),
    .serviced (serviced)
  );

  // {move_up, move_down, door_open}
  assign outs = {move_up, move_down, door_open};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expVal);
    end
  endtask

  // Drive req for one edge, then return 1 unit after that edge.
  task automatic applyStimulus(input logic [NUM_FLOORS-1:0] r);
    req = r;
    @(posedge clk);
    #1;
    req = '0;
  endtask

  // Keep clocking while the door is open; total counts door-open cycles
  // including the startCount already seen. Bounded so a stuck door ends.
  task automatic countDoor(input int startCount, output int total,
                           output int pulses);
    total  = startCount;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus('0);
      if (serviced !== '0) pulses++;
      if (door_open === 1'b1) total++;
      else break;
    end
  endtask

  task automatic resetDut();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    cur_floor = '0;
    at_floor  = 1'b1;
    #1;
    checkOutput("reset_pending", pending, 4'b0000);
    checkOutput("reset_serviced", serviced, 4'b0000);
    checkOutput("reset_outs", outs, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset mid-DOOR with pending=1010
    cur_floor = 2'd2;
    applyStimulus(4'b0100);
    checkOutput("t1_latch", pending, 4'b0100);
    applyStimulus(4'b0000);
    checkOutput("t1_door", outs, 3'b001);
    checkOutput("t1_svc", serviced, 4'b0100);
    applyStimulus(4'b1010);
    checkOutput("t1_pend1010", pending, 4'b1010);
    checkOutput("t1_door_still", outs, 3'b001);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t1_async_door", door_open, 1'b0);
    checkOutput("t1_async_pend", pending, 4'b0000);
    checkOutput("t1_async_svc", serviced, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("t1_after_outs", outs, 3'b000);
    checkOutput("t1_after_pend", pending, 4'b0000);

    // Basic service: floor 0 -> floor 2
    cur_floor = 2'd0;
    at_floor  = 1'b1;
    applyStimulus(4'b0100);
    checkOutput("t2_latch", pending, 4'b0100);
    checkOutput("t2_no_move_yet", outs, 3'b000);
    applyStimulus(4'b0000);
    checkOutput("t2_move_up", outs, 3'b100);
    at_floor = 1'b0;
    applyStimulus(4'b0000);
    checkOutput("t2_travel", outs, 3'b100);
    cur_floor = 2'd1;
    at_floor  = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("t2_pass_floor1", outs, 3'b100);
    at_floor = 1'b0;
    applyStimulus(4'b0000);
    cur_floor = 2'd2;
    at_floor  = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("t2_door", outs, 3'b001);
    checkOutput("t2_svc", serviced, 4'b0100);
    checkOutput("t2_cleared", pending, 4'b0000);
    countDoor(1, doorCycles, svcPulses);
    checkOutput("t2_door_len", doorCycles, 4);
    checkOutput("t2_svc_once", svcPulses, 0);
    checkOutput("t2_idle", outs, 3'b000);

    // Same-floor call at floor 1
    cur_floor = 2'd1;
    applyStimulus(4'b0010);
    checkOutput("t3_latch", pending, 4'b0010);
    checkOutput("t3_no_move", outs, 3'b000);
    applyStimulus(4'b0000);
    checkOutput("t3_door", outs, 3'b001);
    checkOutput("t3_svc", serviced, 4'b0010);
    countDoor(1, doorCycles, svcPulses);
    checkOutput("t3_door_len", doorCycles, 4);
    checkOutput("t3_idle", outs, 3'b000);

    // Direction preference: from floor 1 with 1001
    applyStimulus(4'b1001);
    checkOutput("t4_latch", pending, 4'b1001);
    applyStimulus(4'b0000);
    checkOutput("t4_up", outs, 3'b100);
    at_floor = 1'b0;
    applyStimulus(4'b0000);
    cur_floor = 2'd2;
    at_floor  = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("t4_pass2", outs, 3'b100);
    at_floor = 1'b0;
    applyStimulus(4'b0000);
    cur_floor = 2'd3;
    at_floor  = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("t4_door3", outs, 3'b001);
    checkOutput("t4_svc3", serviced, 4'b1000);
    checkOutput("t4_pend0001", pending, 4'b0001);
    countDoor(1, doorCycles, svcPulses);
    checkOutput("t4_exit_down", outs, 3'b010);
    for (int f = 2; f >= 1; f--) begin
      at_floor = 1'b0;
      applyStimulus(4'b0000);
      cur_floor = FLOOR_W'(f);
      at_floor  = 1'b1;
      applyStimulus(4'b0000);
      checkOutput("t4_pass_down", outs, 3'b010);
    end
    at_floor = 1'b0;
    applyStimulus(4'b0000);
    cur_floor = 2'd0;
    at_floor  = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("t4_door0", outs, 3'b001);
    checkOutput("t4_svc0", serviced, 4'b0001);
    countDoor(1, doorCycles, svcPulses);
    checkOutput("t4_idle", outs, 3'b000);

    // last_dir is now DOWN: door at floor 1 with calls both ways goes down
    cur_floor = 2'd1;
    applyStimulus(4'b0010);
    applyStimulus(4'b0000);
    checkOutput("t4b_door", outs, 3'b001);
    applyStimulus(4'b1001);
    checkOutput("t4b_pend", pending, 4'b1001);
    countDoor(2, doorCycles, svcPulses);
    checkOutput("t4b_exit_down", outs, 3'b010);
    resetDut();

    // Door hold extension at floor 2
    cur_floor = 2'd2;
    at_floor  = 1'b1;
    applyStimulus(4'b0100);
    applyStimulus(4'b0000);
    checkOutput("t5_door", outs, 3'b001);
    applyStimulus(4'b0000);
    applyStimulus(4'b0100);
    checkOutput("t5_absorb_pend", pending, 4'b0000);
    checkOutput("t5_absorb_svc", serviced, 4'b0000);
    countDoor(3, doorCycles, svcPulses);
    checkOutput("t5_door_len", doorCycles, 6);
    checkOutput("t5_no_svc", svcPulses, 0);
    checkOutput("t5_pend_end", pending, 4'b0000);
    checkOutput("t5_idle", outs, 3'b000);
    resetDut();

    // Collision: 1111 during DOOR at floor 0
    cur_floor = 2'd0;
    at_floor  = 1'b1;
    applyStimulus(4'b0001);
    applyStimulus(4'b0000);
    checkOutput("t6_door", outs, 3'b001);
    applyStimulus(4'b1111);
    checkOutput("t6_pend1110", pending, 4'b1110);
    checkOutput("t6_no_svc", serviced, 4'b0000);
    countDoor(2, doorCycles, svcPulses);
    checkOutput("t6_door_len", doorCycles, 5);
    checkOutput("t6_exit_up", outs, 3'b100);
    checkOutput("t6_pend_keep", pending, 4'b1110);

    // Collision: req[cur_floor] on the DOOR entry edge
    at_floor = 1'b0;
    applyStimulus(4'b0000);
    cur_floor = 2'd1;
    at_floor  = 1'b1;
    applyStimulus(4'b0010);
    checkOutput("t6b_door", outs, 3'b001);
    checkOutput("t6b_svc", serviced, 4'b0010);
    checkOutput("t6b_clear_wins", pending, 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floor_request_tracker.md
Name: floor_request_tracker

Overview:
- Receiving end of the per-floor call-button pulse path.
- Latches one-cycle request pulses from the button pulse generators into per-floor pending bits, which also drive the call lamps.
- Runs the car-direction scheduler (collective/SCAN) and the door-hold timer.
- Clears a floor's request when the car services it.
- Sits between the button pulse generators and the motor/door drivers.

Parameters:
- NUM_FLOORS, 4, number of floors and width of the request and lamp vectors.
- FLOOR_W, 2, width of the floor index; must be at least ceil(log2(NUM_FLOORS)).
- HOLD_CYCLES, 4, number of cycles door_open stays high per service; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_FLOORS  one-cycle call pulses, bit i = floor i.
- cur_floor  input  FLOOR_W  current car floor index; valid when at_floor=1.
- at_floor  input  1  level; car is stopped and aligned at cur_floor.
- pending  output  NUM_FLOORS  latched outstanding requests; drives the lamps.
- move_up  output  1  command motor upward.
- move_down  output  1  command motor downward.
- door_open  output  1  door open command.
- serviced  output  NUM_FLOORS  one-hot, one-cycle pulse marking the floor just cleared.

Behaviour:
- Reset (reset=0, asynchronous):
  - pending=0, serviced=0, state=IDLE, hold counter=0, last_dir=UP.
  - move_up, move_down and door_open all 0.
  - Reset mid-operation closes the door and stops the motor immediately; all latched requests are lost.
- Request latching:
  - Each edge: pending[i] <= pending[i] | req[i], except for the clear rules below.
  - Latency: req[i] high at edge E gives pending[i] high after E.
- Derived combinational terms:
  - above = any pending[j] with j > cur_floor.
  - below = any pending[j] with j < cur_floor.
  - here = pending[cur_floor] & at_floor.
  - cur_floor >= NUM_FLOORS: here=0, above=0, below=all pending.
- States: IDLE, UP, DOWN, DOOR. Outputs are Moore:
  - move_up = (state==UP).
  - move_down = (state==DOWN).
  - door_open = (state==DOOR).
  - At most one of the three is ever high.
- IDLE:
  - here -> DOOR.
  - else above -> UP (last_dir=UP).
  - else below -> DOWN (last_dir=DOWN).
  - else stay IDLE.
  - Latency: a request sampled at edge E gives move_up/move_down high after E+1.
- UP:
  - No transition while at_floor=0.
  - With at_floor=1: here -> DOOR; else if !above and below -> DOWN; else if !above -> IDLE; else stay UP.
- DOWN: mirror of UP (swap above/below).
- Entering DOOR (same edge), from any state:
  - pending[cur_floor] <= 0; clear wins over a simultaneous req[cur_floor].
  - serviced[cur_floor] <= 1 for exactly one cycle.
  - counter <= HOLD_CYCLES-1.
- DOOR:
  - door_open=1 for HOLD_CYCLES cycles; counter decrements each edge.
  - req[cur_floor] during DOOR is absorbed: pending is not set, serviced is not pulsed, counter reloads to HOLD_CYCLES-1 (extends the hold).
  - Requests for other floors latch normally.
  - At an edge with counter==0, exit by direction preference:
    - last_dir=UP and above -> UP.
    - else below -> DOWN (last_dir=DOWN).
    - else above -> UP (last_dir=UP).
    - else IDLE.
  - Exit is evaluated with at_floor still 1.
- Multiple simultaneous req bits all latch on the same edge.
- serviced is registered and is 0 in every cycle except the one following DOOR entry.

Test Plan:
- Parameters for all scenarios: NUM_FLOORS=4, HOLD_CYCLES=4.
1. Reset mid-DOOR: assert reset=0 asynchronously while door_open=1 and pending=1010 -> door_open=0, pending=0000, serviced=0000 before the next clk edge; after release, state is IDLE with all outputs 0.
2. Basic service: car at floor 0, at_floor=1, pulse req=0100 -> pending=0100 next cycle, move_up the cycle after.
   - Step cur_floor to 1 with at_floor=1 -> move_up stays 1.
   - cur_floor=2 with at_floor=1 -> serviced=0100 for one cycle, pending=0000, door_open high exactly 4 cycles, then IDLE with all outputs 0.
3. Same-floor call: IDLE at floor 1, pulse req=0010 -> door opens with no move_up/move_down cycle; serviced=0010.
4. Direction preference: moving UP from floor 1 with pending=1001 -> car services floor 3 first, then the DOOR exit goes to DOWN; floor 0 is serviced last; last_dir ends DOWN.
5. Door hold extension: in DOOR at floor 2, pulse req=0100 on the third door cycle -> door_open total of 6 cycles, no second serviced pulse, pending stays 0000.
6. Collision cases:
   - req=1111 in one cycle while in DOOR at floor 0 -> pending=1110; exit goes UP.
   - req[cur_floor] on the same edge as DOOR entry -> pending bit stays 0.
